regfile_wb_arbiter: RTL and testbench

Sequences the register file's single write port between two writeback sources: the in-order pipeline, which has priority and no buffering, and the multi-cycle multdiv unit, which uses valid/ready with a 2-entry buffer. The block tracks registers with an outstanding multdiv result in a 32-bit scoreboard and reports read hazards to decode. It guarantees that multdiv cannot starve. It sits between the writeback stage / multdiv unit and the regfile's ctrl_writeEnable / ctrl_writeReg / data_writeReg inputs.

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter_wb_fifo2.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, grant encoding and buffer entry type for the regfile
// writeback arbiter.
package regfile_wb_arbiter_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      GNT_IDLE  = 2'd0,
      GNT_PIPE  = 2'd1,
      GNT_MD    = 2'd2,
      GNT_FORCE = 2'd3
   } grant_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: pipeline writeback plus multdiv issue/result
// handshake.
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
();
   logic                  pipe_we;
   logic [REG_ADDR_W-1:0] pipe_rd;
   logic [DATA_W-1:0]     pipe_data;
   logic                  pipe_stall;
   logic                  md_issue;
   logic [REG_ADDR_W-1:0] md_issue_rd;
   logic                  md_valid;
   logic [REG_ADDR_W-1:0] md_rd;
   logic [DATA_W-1:0]     md_data;
   logic                  md_ready;

   modport master (
      output pipe_we, pipe_rd, pipe_data, md_issue, md_issue_rd,
             md_valid, md_rd, md_data,
      input  pipe_stall, md_ready
   );

   modport slave (
      input  pipe_we, pipe_rd, pipe_data, md_issue, md_issue_rd,
             md_valid, md_rd, md_data,
      output pipe_stall, md_ready
   );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo2.sv
// Two-entry synchronous FIFO holding multdiv results awaiting the write port.
// Pushes while full and pops while empty are ignored.
module wb_fifo2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic      clk,
   input  logic      srst,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output wb_entry_t head,
   output logic [1:0] count,
   output logic      full,
   output logic      empty
);
   wb_entry_t  mem [2];
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic       do_push;
   logic       do_pop;

   assign full    = (count_reg == 2'd2);
   assign empty   = (count_reg == 2'd0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];

   // Storage carries no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between the pipeline (priority) and a
// buffered multdiv unit, with starvation guard and pending-write scoreboard.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  ctrl_reset,
   regfile_wb_arbiter_if.slave   wb,
   input  logic [REG_ADDR_W-1:0] rd_a,
   input  logic [REG_ADDR_W-1:0] rd_b,
   output logic                  hazard_a,
   output logic                  hazard_b,
   output logic                  ctrl_writeEnable,
   output logic [REG_ADDR_W-1:0] ctrl_writeReg,
   output logic [DATA_W-1:0]     data_writeReg,
   output logic                  err_waw
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   wb_entry_t             head;
   logic [1:0]            count;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  force_grant;
   grant_t                grant;
   logic [3:0]            starve_reg, starve_next;
   logic [NUM_REGS-1:0]   pending_reg, pending_next;
   logic                  err_reg, err_next;
   logic                  we_reg, we_next;
   logic [REG_ADDR_W-1:0] wreg_reg, wreg_next;
   logic [DATA_W-1:0]     wdata_reg, wdata_next;

   wb_fifo2 u_fifo (
      .clk        (clock),
      .srst       (ctrl_reset),
      .push       (push),
      .push_entry ({wb.md_rd, wb.md_data}),
      .pop        (pop),
      .head       (head),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   assign wb.md_ready   = !full;
   assign push          = wb.md_valid && !full;
   assign force_grant   = (count != 2'd0) && (starve_reg == LIMIT);
   assign wb.pipe_stall = force_grant;

   always_comb begin
      grant = GNT_IDLE;
      if (force_grant)
         grant = GNT_FORCE;
      else if (wb.pipe_we && wb.pipe_rd != '0)
         grant = GNT_PIPE;
      else if (!empty)
         grant = GNT_MD;
   end

   assign pop = (grant == GNT_FORCE) || (grant == GNT_MD);

   always_comb begin
      starve_next = starve_reg;
      if (empty || pop)
         starve_next = 4'd0;
      else if (starve_reg != LIMIT)
         starve_next = starve_reg + 4'd1;
   end

   // Write presented next cycle; an r0 head is consumed without a write.
   always_comb begin
      we_next    = 1'b0;
      wreg_next  = '0;
      wdata_next = '0;
      case (grant)
         GNT_PIPE: begin
            we_next    = 1'b1;
            wreg_next  = wb.pipe_rd;
            wdata_next = wb.pipe_data;
         end
         GNT_MD, GNT_FORCE: begin
            if (head.rd != '0) begin
               we_next    = 1'b1;
               wreg_next  = head.rd;
               wdata_next = head.data;
            end
         end
         default: ;
      endcase
   end

   // Issue sets after grant clears so a same-cycle collision stays pending.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      if (gi == 0) begin : g_r0
         assign pending_next[gi] = 1'b0;
      end else begin : g_rn
         logic set_bit, clr_bit;
         assign set_bit = wb.md_issue && (wb.md_issue_rd == REG_ADDR_W'(gi));
         assign clr_bit = pop && (head.rd == REG_ADDR_W'(gi));
         assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
      end
   end

   assign err_next = err_reg || (wb.md_issue && pending_reg[wb.md_issue_rd]);

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         starve_reg  <= 4'd0;
         pending_reg <= '0;
         err_reg     <= 1'b0;
         we_reg      <= 1'b0;
         wreg_reg    <= '0;
         wdata_reg   <= '0;
      end else begin
         starve_reg  <= starve_next;
         pending_reg <= pending_next;
         err_reg     <= err_next;
         we_reg      <= we_next;
         wreg_reg    <= wreg_next;
         wdata_reg   <= wdata_next;
      end
   end

   assign hazard_a         = pending_reg[rd_a];
   assign hazard_b         = pending_reg[rd_b];
   assign ctrl_writeEnable = we_reg;
   assign ctrl_writeReg    = wreg_reg;
   assign data_writeReg    = wdata_reg;
   assign err_waw          = err_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed check of regfile_wb_arbiter against a queue-based
// behavioural model of the write-port arbitration rules.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int LIMIT = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic [4:0]  rd_a, rd_b;
   logic        hazard_a, hazard_b;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        err_waw;

   always #5 clock = ~clock;

   regfile_wb_arbiter_if wb ();

   regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .wb               (wb),
      .rd_a             (rd_a),
      .rd_b             (rd_b),
      .hazard_a         (hazard_a),
      .hazard_b         (hazard_b),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .err_waw          (err_waw)
   );

   // Model state
   ent_t        mq[$];
   ent_t        src_q[$];
   int          starve;
   bit [31:0]   pend;
   bit          err;
   bit          exp_we;
   bit [4:0]    exp_reg;
   bit [31:0]   exp_data;
   logic [4:0]  bp_log[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      src_q.delete();
      starve   = 0;
      pend     = '0;
      err      = 1'b0;
      exp_we   = 1'b0;
      exp_reg  = '0;
      exp_data = '0;
   endtask

   // One clock cycle: called just after a rising edge with inputs set.
   task automatic cyc();
      ent_t      h;
      bit        m_ready, m_force, preq, was_empty, head_gnt;
      bit        n_we;
      bit [4:0]  n_reg;
      bit [31:0] n_data;
      bit [31:0] n_pend;
      wb.md_valid = (src_q.size() > 0);
      wb.md_rd    = (src_q.size() > 0) ? src_q[0].rd : 5'd0;
      wb.md_data  = (src_q.size() > 0) ? src_q[0].data : 32'd0;
      @(negedge clock);
      m_ready   = (mq.size() < 2);
      m_force   = (mq.size() > 0) && (starve == LIMIT);
      preq      = wb.pipe_we && (wb.pipe_rd != 5'd0);
      was_empty = (mq.size() == 0);
      chk("md_ready", wb.md_ready, m_ready);
      chk("pipe_stall", wb.pipe_stall, m_force);
      chk("hazard_a", hazard_a, pend[rd_a]);
      chk("hazard_b", hazard_b, pend[rd_b]);
      chk("err_waw", err_waw, err);
      chk("write_en", ctrl_writeEnable, exp_we);
      if (exp_we) begin
         chk("write_reg", ctrl_writeReg, exp_reg);
         chk("write_data", data_writeReg, exp_data);
      end
      if (ctrl_writeEnable === 1'b1) begin
         $display("t=%0t write r%0d <= %08h", $time, ctrl_writeReg, data_writeReg);
         if (ctrl_writeReg >= 5'd10 && ctrl_writeReg <= 5'd12) bp_log.push_back(ctrl_writeReg);
      end
      // Next-state of the model
      n_we = 1'b0; n_reg = '0; n_data = '0; head_gnt = 1'b0;
      n_pend = pend;
      if (m_force || (!preq && !was_empty)) begin
         h = mq.pop_front();
         head_gnt = 1'b1;
         if (h.rd != 5'd0) begin
            n_we = 1'b1; n_reg = h.rd; n_data = h.data;
            n_pend[h.rd] = 1'b0;
         end
      end else if (preq) begin
         n_we = 1'b1; n_reg = wb.pipe_rd; n_data = wb.pipe_data;
      end
      if (wb.md_valid && m_ready) begin
         mq.push_back(src_q.pop_front());
      end
      if (was_empty || head_gnt) starve = 0;
      else if (starve < LIMIT) starve++;
      if (wb.md_issue) begin
         if (pend[wb.md_issue_rd]) err = 1'b1;
         if (wb.md_issue_rd != 5'd0) n_pend[wb.md_issue_rd] = 1'b1;
      end
      pend = n_pend;
      exp_we = n_we; exp_reg = n_reg; exp_data = n_data;
      if (ctrl_reset) model_reset();
      @(posedge clock);
      #1;
   endtask

   initial begin
      ctrl_reset     = 1'b1;
      wb.pipe_we     = 1'b0;
      wb.pipe_rd     = '0;
      wb.pipe_data   = '0;
      wb.md_issue    = 1'b0;
      wb.md_issue_rd = '0;
      wb.md_valid    = 1'b0;
      wb.md_rd       = '0;
      wb.md_data     = '0;
      rd_a = 5'd5;
      rd_b = 5'd9;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      ctrl_reset = 1'b0;
      chk("rst_we", ctrl_writeEnable, 1'b0);
      chk("rst_reg", ctrl_writeReg, 5'd0);
      chk("rst_data", data_writeReg, 32'd0);
      chk("rst_ready", wb.md_ready, 1'b1);
      chk("rst_stall", wb.pipe_stall, 1'b0);
      chk("rst_err", err_waw, 1'b0);

      // Pipeline only
      wb.pipe_we = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = 32'hDEADBEEF;
      cyc();
      chk("pipe_we_lit", ctrl_writeEnable, 1'b1);
      chk("pipe_reg_lit", ctrl_writeReg, 5'd3);
      chk("pipe_data_lit", data_writeReg, 32'hDEADBEEF);
      wb.pipe_rd = 5'd0; wb.pipe_data = 32'h12345678;
      cyc();
      chk("pipe_r0_lit", ctrl_writeEnable, 1'b0);
      wb.pipe_we = 1'b0;

      // Scoreboard
      rd_a = 5'd5;
      wb.md_issue = 1'b1; wb.md_issue_rd = 5'd5;
      cyc();
      wb.md_issue = 1'b0;
      chk("sb_hazard_set_lit", hazard_a, 1'b1);
      cyc();
      cyc();
      src_q.push_back('{5'd5, 32'd7});
      cyc();
      cyc();
      chk("sb_we_lit", ctrl_writeEnable, 1'b1);
      chk("sb_reg_lit", ctrl_writeReg, 5'd5);
      chk("sb_data_lit", data_writeReg, 32'd7);
      chk("sb_hazard_clr_lit", hazard_a, 1'b0);

      // Starvation
      wb.pipe_we = 1'b1; wb.pipe_rd = 5'd2; wb.pipe_data = 32'h00001111;
      src_q.push_back('{5'd7, 32'h55});
      repeat (5) cyc();
      chk("starve_stall_lit", wb.pipe_stall, 1'b1);
      chk("starve_prev_reg_lit", ctrl_writeReg, 5'd2);
      cyc();
      chk("starve_md_reg_lit", ctrl_writeReg, 5'd7);
      chk("starve_md_data_lit", data_writeReg, 32'h55);
      chk("starve_stall_off_lit", wb.pipe_stall, 1'b0);
      cyc();
      chk("starve_held_reg_lit", ctrl_writeReg, 5'd2);
      chk("starve_held_data_lit", data_writeReg, 32'h00001111);

      // Backpressure
      bp_log.delete();
      src_q.push_back('{5'd10, 32'hA0});
      src_q.push_back('{5'd11, 32'hA1});
      src_q.push_back('{5'd12, 32'hA2});
      cyc();
      cyc();
      chk("bp_ready_lit", wb.md_ready, 1'b0);
      repeat (8) cyc();
      wb.pipe_we = 1'b0;
      repeat (4) cyc();
      chk("bp_order_lit",
          (bp_log.size() == 3) ? {17'd0, bp_log[0], bp_log[1], bp_log[2]} : 32'hFFFFFFFF,
          {17'd0, 5'd10, 5'd11, 5'd12});

      // Error flag
      wb.md_issue = 1'b1; wb.md_issue_rd = 5'd9;
      cyc();
      cyc();
      wb.md_issue = 1'b0;
      chk("waw_set_lit", err_waw, 1'b1);
      wb.pipe_we = 1'b1; wb.pipe_rd = 5'd4; wb.pipe_data = 32'hCAFE0000;
      repeat (3) cyc();
      chk("waw_sticky_lit", err_waw, 1'b1);
      ctrl_reset = 1'b1;
      cyc();
      ctrl_reset = 1'b0;
      chk("waw_clr_lit", err_waw, 1'b0);

      // Reset mid-operation with full buffer and pending bits
      wb.md_issue = 1'b1; wb.md_issue_rd = 5'd20;
      src_q.push_back('{5'd20, 32'hB0});
      src_q.push_back('{5'd21, 32'hB1});
      cyc();
      wb.md_issue = 1'b0;
      cyc();
      rd_a = 5'd20;
      chk("mid_full_lit", wb.md_ready, 1'b0);
      ctrl_reset = 1'b1;
      cyc();
      ctrl_reset = 1'b0;
      wb.pipe_we = 1'b0;
      chk("mid_we_lit", ctrl_writeEnable, 1'b0);
      chk("mid_reg_lit", ctrl_writeReg, 5'd0);
      chk("mid_data_lit", data_writeReg, 32'd0);
      chk("mid_ready_lit", wb.md_ready, 1'b1);
      chk("mid_stall_lit", wb.pipe_stall, 1'b0);
      chk("mid_hazard_lit", hazard_a, 1'b0);
      repeat (6) cyc();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         wb.pipe_we     = ($urandom_range(0, 9) < 6);
         wb.pipe_rd     = 5'($urandom_range(0, 31));
         wb.pipe_data   = $urandom;
         wb.md_issue    = ($urandom_range(0, 4) == 0);
         wb.md_issue_rd = 5'($urandom_range(0, 7));
         if (src_q.size() < 2 && $urandom_range(0, 3) == 0)
            src_q.push_back('{5'($urandom_range(0, 7)), $urandom});
         rd_a       = 5'($urandom_range(0, 7));
         rd_b       = 5'($urandom_range(0, 7));
         ctrl_reset = ($urandom_range(0, 99) == 0);
         cyc();
      end
      ctrl_reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
